// File: rtl/dmem_access_pkg.sv
// ----------------------------------------------------------------------------
// dmem_access_pkg
// Shared definitions for the memory-stage controller:
//   - data path width (fixed at 32 for RV32)
//   - RISC-V load/store funct3 encodings
//   - FSM state encoding
//   - helper that flags an access whose address is not naturally aligned
// ----------------------------------------------------------------------------
package dmem_access_pkg;

    localparam int DMEM_DATA_W = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10
    } dmem_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, anything else a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// ----------------------------------------------------------------------------
// dmem_access_if
// Data-memory bus between the memory-stage controller and the memory.
//   master (controller): drives dmem_req, dmem_we, dmem_addr, dmem_be,
//                        dmem_wdata; receives dmem_gnt, dmem_rvalid, dmem_rdata
//   slave  (memory):     the mirror image
// ----------------------------------------------------------------------------
interface dmem_access_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/dmem_access_load_align.sv
// ----------------------------------------------------------------------------
// dmem_access_load_align
// Combinational load alignment: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it according to funct3.
//   rdata   in  32  raw word from the data memory
//   addr_lo in  2   byte offset of the load address
//   funct3  in  3   RISC-V load funct3 (011/110/111 behave as LW)
//   data    out 32  aligned, extended load result
// ----------------------------------------------------------------------------
module dmem_access_load_align
    import dmem_access_pkg::*;
(
    input  logic [DMEM_DATA_W-1:0] rdata,
    input  logic [1:0]             addr_lo,
    input  logic [2:0]             funct3,
    output logic [DMEM_DATA_W-1:0] data
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (funct3)
            FUNCT3_LB:  data = ext_byte(byte_sel, 1'b1);
            FUNCT3_LBU: data = ext_byte(byte_sel, 1'b0);
            FUNCT3_LH:  data = ext_half(half_sel, 1'b1);
            FUNCT3_LHU: data = ext_half(half_sel, 1'b0);
            FUNCT3_LW:  data = rdata;
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// ----------------------------------------------------------------------------
// dmem_access
// Memory-stage controller between EX and wb_ctrl. Accepts one instruction per
// mem_valid_ex/mem_ready handshake, runs loads and stores on the data-memory
// bus with byte-lane steering, aligns load data and registers the result into
// the WB-stage register.
//
// Ports
//   cpu_clk, cpu_rst         clock; asynchronous active-high reset
//   mem_valid_ex/mem_ready   EX handshake
//   alu_result_ex, alu_result_valid_ex, load_ex, store_ex, mem_funct3_ex,
//   store_data_ex            EX instruction fields
//   dmem                     data-memory bus (dmem_access_if.master)
//   alu_result_wb, alu_result_valid_wb, load_wb, load_data_wb,
//   load_data_valid_wb       WB-stage register to wb_ctrl
//   wb_ready                 WB consumes the WB register this cycle
//   misalign_exc_wb          misaligned-access flag (DMEM_MISALIGN_TRAP_EN only)
//
// Build option: define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently ignoring the low address bits.
// ----------------------------------------------------------------------------
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  mem_valid_ex,
    output logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] alu_result_ex,
    input  logic                  alu_result_valid_ex,
    input  logic                  load_ex,
    input  logic                  store_ex,
    input  logic [2:0]            mem_funct3_ex,
    input  logic [DATA_WIDTH-1:0] store_data_ex,
    dmem_access_if.master         dmem,
    output logic [DATA_WIDTH-1:0] alu_result_wb,
    output logic                  alu_result_valid_wb,
    output logic                  load_wb,
    output logic [DATA_WIDTH-1:0] load_data_wb,
    output logic                  load_data_valid_wb,
    input  logic                  wb_ready
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_exc_wb
`endif
);

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across all lanes so be alone picks the bytes.
    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    dmem_state_e           state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] ld_addr_q, ld_addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  is_load_q, is_load_d;

    logic [DATA_WIDTH-1:0] wb_alu_q, wb_alu_d;
    logic                  wb_alu_vld_q, wb_alu_vld_d;
    logic                  wb_load_q, wb_load_d;
    logic [DATA_WIDTH-1:0] wb_ldata_q, wb_ldata_d;
    logic                  wb_ldata_vld_q, wb_ldata_vld_d;
    logic                  wb_mis_q, wb_mis_d;

    logic                  wb_full;
    logic                  accept;
    logic                  ex_misaligned;
    logic [DATA_WIDTH-1:0] aligned_data;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign ex_misaligned = is_misaligned(mem_funct3_ex[1:0], alu_result_ex[1:0]);
`else
    assign ex_misaligned = 1'b0;
`endif

    // A held WB entry blocks new work only when WB is not draining it now.
    assign wb_full   = wb_alu_vld_q | wb_ldata_vld_q | wb_mis_q;
    assign mem_ready = !cpu_rst && (state_q == ST_IDLE) && !(wb_full && !wb_ready);
    assign accept    = mem_valid_ex && mem_ready;

    dmem_access_load_align u_load_align (
        .rdata   (dmem.dmem_rdata),
        .addr_lo (ld_addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (aligned_data)
    );

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        ld_addr_d      = ld_addr_q;
        funct3_d       = funct3_q;
        is_load_d      = is_load_q;
        wb_alu_d       = wb_alu_q;
        wb_alu_vld_d   = wb_alu_vld_q;
        wb_load_d      = wb_load_q;
        wb_ldata_d     = wb_ldata_q;
        wb_ldata_vld_d = wb_ldata_vld_q;
        wb_mis_d       = wb_mis_q;

        // WB consumed this cycle: drop the flags, keep the data. Any entry
        // loaded below in the same cycle overrides this.
        if (wb_ready) begin
            wb_alu_vld_d   = 1'b0;
            wb_load_d      = 1'b0;
            wb_ldata_vld_d = 1'b0;
            wb_mis_d       = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (load_ex || store_ex) begin
                        if (ex_misaligned) begin
                            wb_alu_d       = alu_result_ex;
                            wb_alu_vld_d   = 1'b0;
                            wb_load_d      = 1'b0;
                            wb_ldata_vld_d = 1'b0;
                            wb_mis_d       = 1'b1;
                        end else begin
                            state_d   = ST_REQ;
                            req_d     = 1'b1;
                            we_d      = !load_ex;
                            addr_d    = {alu_result_ex[ADDR_WIDTH-1:2], 2'b00};
                            be_d      = lane_be(mem_funct3_ex[1:0], alu_result_ex[1:0]);
                            wdata_d   = load_ex ? '0 : lane_wdata(mem_funct3_ex[1:0], store_data_ex);
                            ld_addr_d = alu_result_ex;
                            funct3_d  = mem_funct3_ex;
                            is_load_d = load_ex;
                        end
                    end else begin
                        wb_alu_d       = alu_result_ex;
                        wb_alu_vld_d   = alu_result_valid_ex;
                        wb_load_d      = 1'b0;
                        wb_ldata_vld_d = 1'b0;
                        wb_mis_d       = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                // Bus fields hold until the grant; rvalid is not looked at here.
                if (dmem.dmem_gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = is_load_q ? ST_WAIT_R : ST_IDLE;
                end
            end
            ST_WAIT_R: begin
                if (dmem.dmem_rvalid) begin
                    wb_alu_d       = ld_addr_q;
                    wb_alu_vld_d   = 1'b0;
                    wb_load_d      = 1'b1;
                    wb_ldata_d     = aligned_data;
                    wb_ldata_vld_d = 1'b1;
                    wb_mis_d       = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q        <= ST_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            ld_addr_q      <= '0;
            funct3_q       <= '0;
            is_load_q      <= 1'b0;
            wb_alu_q       <= '0;
            wb_alu_vld_q   <= 1'b0;
            wb_load_q      <= 1'b0;
            wb_ldata_q     <= '0;
            wb_ldata_vld_q <= 1'b0;
            wb_mis_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            ld_addr_q      <= ld_addr_d;
            funct3_q       <= funct3_d;
            is_load_q      <= is_load_d;
            wb_alu_q       <= wb_alu_d;
            wb_alu_vld_q   <= wb_alu_vld_d;
            wb_load_q      <= wb_load_d;
            wb_ldata_q     <= wb_ldata_d;
            wb_ldata_vld_q <= wb_ldata_vld_d;
            wb_mis_q       <= wb_mis_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign alu_result_wb       = wb_alu_q;
    assign alu_result_valid_wb = wb_alu_vld_q;
    assign load_wb             = wb_load_q;
    assign load_data_wb        = wb_ldata_q;
    assign load_data_valid_wb  = wb_ldata_vld_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_exc_wb = wb_mis_q;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// ----------------------------------------------------------------------------
// tb_dmem_access
// Directed bench for dmem_access: ALU pass-through, loads of every width,
// stores with lane steering and delayed grant, WB back-pressure, reset during
// a transaction, and (with DMEM_MISALIGN_TRAP_EN) the misalignment trap.
// ----------------------------------------------------------------------------
module tb_dmem_access;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        mem_valid_ex;
    logic        mem_ready;
    logic [31:0] alu_result_ex;
    logic        alu_result_valid_ex;
    logic        load_ex;
    logic        store_ex;
    logic [2:0]  mem_funct3_ex;
    logic [31:0] store_data_ex;
    logic [31:0] alu_result_wb;
    logic        alu_result_valid_wb;
    logic        load_wb;
    logic [31:0] load_data_wb;
    logic        load_data_valid_wb;
    logic        wb_ready;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign_exc_wb;
`endif

    dmem_access_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dmem_bus ();

    dmem_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .cpu_clk             (cpu_clk),
        .cpu_rst             (cpu_rst),
        .mem_valid_ex        (mem_valid_ex),
        .mem_ready           (mem_ready),
        .alu_result_ex       (alu_result_ex),
        .alu_result_valid_ex (alu_result_valid_ex),
        .load_ex             (load_ex),
        .store_ex            (store_ex),
        .mem_funct3_ex       (mem_funct3_ex),
        .store_data_ex       (store_data_ex),
        .dmem                (dmem_bus),
        .alu_result_wb       (alu_result_wb),
        .alu_result_valid_wb (alu_result_valid_wb),
        .load_wb             (load_wb),
        .load_data_wb        (load_data_wb),
        .load_data_valid_wb  (load_data_valid_wb),
        .wb_ready            (wb_ready)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc_wb     (misalign_exc_wb)
`endif
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } ld_vec_t;

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          gnt_dly;
    } st_vec_t;

    ld_vec_t ld_tab[5];
    st_vec_t st_tab[5];

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
        mem_valid_ex  = 1'b1;
        load_ex       = 1'b1;
        store_ex      = 1'b0;
        mem_funct3_ex = f3;
        alu_result_ex = addr;
        step();
        mem_valid_ex  = 1'b0;
        load_ex       = 1'b0;
        check({tag, ".req"},   {31'd0, dmem_bus.dmem_req}, 32'd1);
        check({tag, ".we"},    {31'd0, dmem_bus.dmem_we}, 32'd0);
        check({tag, ".addr"},  dmem_bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, ".ready"}, {31'd0, mem_ready}, 32'd0);
        dmem_bus.dmem_gnt = 1'b1;
        step();
        dmem_bus.dmem_gnt    = 1'b0;
        check({tag, ".req_off"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rdata;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        check({tag, ".load_wb"}, {31'd0, load_wb}, 32'd1);
        check({tag, ".ldvld"},   {31'd0, load_data_valid_wb}, 32'd1);
        check({tag, ".data"},    load_data_wb, exp_data);
        check({tag, ".wbaddr"},  alu_result_wb, addr);
    endtask

    task automatic do_store(input st_vec_t v);
        mem_valid_ex  = 1'b1;
        load_ex       = 1'b0;
        store_ex      = 1'b1;
        mem_funct3_ex = v.f3;
        alu_result_ex = v.addr;
        store_data_ex = v.data;
        step();
        mem_valid_ex  = 1'b0;
        store_ex      = 1'b0;
        for (int i = 0; i <= v.gnt_dly; i++) begin
            check({v.tag, ".req"},   {31'd0, dmem_bus.dmem_req}, 32'd1);
            check({v.tag, ".we"},    {31'd0, dmem_bus.dmem_we}, 32'd1);
            check({v.tag, ".addr"},  dmem_bus.dmem_addr, {v.addr[31:2], 2'b00});
            check({v.tag, ".be"},    {28'd0, dmem_bus.dmem_be}, {28'd0, v.exp_be});
            check({v.tag, ".wdata"}, dmem_bus.dmem_wdata, v.exp_wdata);
            check({v.tag, ".ready"}, {31'd0, mem_ready}, 32'd0);
            if (i < v.gnt_dly) step();
        end
        dmem_bus.dmem_gnt = 1'b1;
        step();
        dmem_bus.dmem_gnt = 1'b0;
        check({v.tag, ".req_off"},  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check({v.tag, ".ready_n2"}, {31'd0, mem_ready}, 32'd1);
        check({v.tag, ".no_wb"},    {30'd0, alu_result_valid_wb, load_data_valid_wb}, 32'd0);
    endtask

    initial begin
        ld_tab[0] = '{"lb103",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80};
        ld_tab[1] = '{"lbu102", 3'b100, 32'h0000_0102, 32'h80FF_0000, 32'h0000_00FF};
        ld_tab[2] = '{"lh002",  3'b001, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001};
        ld_tab[3] = '{"lw010",  3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        ld_tab[4] = '{"lb101",  3'b000, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F};

        st_tab[0] = '{"sh202", 3'b001, 32'h0000_0202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 3};
        st_tab[1] = '{"sb001", 3'b000, 32'h0000_0001, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A, 0};
        st_tab[2] = '{"sw040", 3'b010, 32'h0000_0040, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF, 1};
        st_tab[3] = '{"sh000", 3'b001, 32'h0000_0000, 32'hFFFF_1357, 4'b0011, 32'h1357_1357, 0};
        st_tab[4] = '{"sb003", 3'b000, 32'h0000_0003, 32'h0000_00C3, 4'b1000, 32'hC3C3_C3C3, 0};

        cpu_rst             = 1'b1;
        mem_valid_ex        = 1'b0;
        alu_result_ex       = '0;
        alu_result_valid_ex = 1'b0;
        load_ex             = 1'b0;
        store_ex            = 1'b0;
        mem_funct3_ex       = '0;
        store_data_ex       = '0;
        wb_ready            = 1'b1;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = '0;

        // Reset state
        #2;
        check("rst.req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rst.we",    {31'd0, dmem_bus.dmem_we}, 32'd0);
        check("rst.addr",  dmem_bus.dmem_addr, 32'd0);
        check("rst.be",    {28'd0, dmem_bus.dmem_be}, 32'd0);
        check("rst.wdata", dmem_bus.dmem_wdata, 32'd0);
        check("rst.wb",    {29'd0, alu_result_valid_wb, load_wb, load_data_valid_wb}, 32'd0);
        check("rst.wbalu", alu_result_wb, 32'd0);
        check("rst.wbld",  load_data_wb, 32'd0);
        check("rst.ready", {31'd0, mem_ready}, 32'd0);
        step();
        step();
        cpu_rst = 1'b0;
        #1;
        check("rel.ready", {31'd0, mem_ready}, 32'd1);

        // ALU pass-through
        mem_valid_ex        = 1'b1;
        alu_result_ex       = 32'h1234_5678;
        alu_result_valid_ex = 1'b1;
        step();
        mem_valid_ex = 1'b0;
        check("alu.wb",    alu_result_wb, 32'h1234_5678);
        check("alu.vld",   {31'd0, alu_result_valid_wb}, 32'd1);
        check("alu.ld",    {31'd0, load_wb}, 32'd0);
        check("alu.req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        step();
        check("alu.clr",   {31'd0, alu_result_valid_wb}, 32'd0);

        // Back-to-back ALU ops, one WB entry per cycle
        mem_valid_ex  = 1'b1;
        alu_result_ex = 32'h0000_0011;
        step();
        check("b2b0.wb",  alu_result_wb, 32'h0000_0011);
        check("b2b0.vld", {31'd0, alu_result_valid_wb}, 32'd1);
        alu_result_ex       = 32'h0000_0022;
        alu_result_valid_ex = 1'b0;
        step();
        check("b2b1.wb",  alu_result_wb, 32'h0000_0022);
        check("b2b1.vld", {31'd0, alu_result_valid_wb}, 32'd0);
        alu_result_ex = 32'h0000_0033;
        alu_result_valid_ex = 1'b1;
        step();
        mem_valid_ex = 1'b0;
        check("b2b2.wb",  alu_result_wb, 32'h0000_0033);
        check("b2b2.vld", {31'd0, alu_result_valid_wb}, 32'd1);
        step();

        // Loads
        for (int i = 0; i < 5; i++)
            do_load(ld_tab[i].tag, ld_tab[i].f3, ld_tab[i].addr, ld_tab[i].rdata, ld_tab[i].exp_data);
`ifndef DMEM_MISALIGN_TRAP_EN
        // funct3 110 is a word access; the low address bits are ignored
        do_load("w110", 3'b110, 32'h0000_0021, 32'hCAFE_F00D, 32'hCAFE_F00D);
`endif
        step();

        // Stores
        for (int i = 0; i < 5; i++)
            do_store(st_tab[i]);

        // LHU with WB back-pressure
        wb_ready = 1'b0;
        do_load("lhu000", 3'b101, 32'h0000_0000, 32'h0000_F00D, 32'h0000_F00D);
        check("bp.ready0", {31'd0, mem_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp.hold",  load_data_wb, 32'h0000_F00D);
            check("bp.vld",   {31'd0, load_data_valid_wb}, 32'd1);
            check("bp.ready", {31'd0, mem_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        #1;
        check("bp.ready1", {31'd0, mem_ready}, 32'd1);
        step();
        check("bp.clr", {31'd0, load_data_valid_wb}, 32'd0);

        // Reset while the request is outstanding
        mem_valid_ex  = 1'b1;
        load_ex       = 1'b1;
        mem_funct3_ex = 3'b010;
        alu_result_ex = 32'h0000_0050;
        step();
        mem_valid_ex = 1'b0;
        load_ex      = 1'b0;
        check("rreq.req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        #2;
        cpu_rst = 1'b1;
        #1;
        check("rreq.req0",  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rreq.addr0", dmem_bus.dmem_addr, 32'd0);
        check("rreq.rdy0",  {31'd0, mem_ready}, 32'd0);
        step();
        cpu_rst = 1'b0;
        #1;
        check("rreq.rdy1", {31'd0, mem_ready}, 32'd1);

        // Reset in WAIT_R; a late rvalid must not create a WB entry
        mem_valid_ex  = 1'b1;
        load_ex       = 1'b1;
        mem_funct3_ex = 3'b010;
        alu_result_ex = 32'h0000_0060;
        step();
        mem_valid_ex = 1'b0;
        load_ex      = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        step();
        dmem_bus.dmem_gnt = 1'b0;
        check("rwr.ready", {31'd0, mem_ready}, 32'd0);
        cpu_rst = 1'b1;
        #1;
        check("rwr.req0",  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rwr.rdy0",  {31'd0, mem_ready}, 32'd0);
        step();
        cpu_rst = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h1111_1111;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        check("rwr.nowb",  {30'd0, load_wb, load_data_valid_wb}, 32'd0);
        check("rwr.data",  load_data_wb, 32'd0);
        check("rwr.rdy1",  {31'd0, mem_ready}, 32'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
        // Misaligned LW: no bus request, exception in the WB register
        mem_valid_ex  = 1'b1;
        load_ex       = 1'b1;
        mem_funct3_ex = 3'b010;
        alu_result_ex = 32'h0000_0006;
        step();
        mem_valid_ex = 1'b0;
        load_ex      = 1'b0;
        check("mis.req",  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("mis.exc",  {31'd0, misalign_exc_wb}, 32'd1);
        check("mis.addr", alu_result_wb, 32'h0000_0006);
        check("mis.vlds", {29'd0, alu_result_valid_wb, load_wb, load_data_valid_wb}, 32'd0);
        step();
        check("mis.clr",  {31'd0, misalign_exc_wb}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
